// File: rtl/ref_bit_checker_if.sv
// Received-bit stream between the demapper and the reference-bit checker.
// The source drives valid/bit and the checker answers with ready; a bit is
// transferred on any clock edge where in_valid and in_ready are both high.
interface ref_bit_checker_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/ref_bit_checker.sv
// ref_bit_checker: on-chip BER monitor at the end of the receiver chain.
// Walks the 1-bit reference ROM (addresses 0..N-1) in step with the demapped
// bit stream, XOR-compares each received bit with its reference bit and
// counts errors per OFDM symbol (err_sym) and in total (err_total, saturating).
// Optional feature: define REF_CHK_FIRST_ERR_EN to add first_err_vld /
// first_err_idx, which report the ROM index of the first mismatch in a symbol.
// Reset rst_n is asynchronous and active-high, despite its name.
module ref_bit_checker #(
  parameter int N     = 48,
  parameter int LOG2N = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  ref_bit_checker_if.slave bit_if,
  output logic [LOG2N-1:0] rom_addr,
  output logic             rom_we,
  input  logic             rom_data,
  output logic             busy,
  output logic             sym_done,
  output logic [LOG2N:0]   err_sym,
  output logic [CNT_W-1:0] err_total,
  output logic [CNT_W-1:0] sym_cnt
`ifdef REF_CHK_FIRST_ERR_EN
  ,
  output logic             first_err_vld,
  output logic [LOG2N-1:0] first_err_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] LAST_ADDR = LOG2N'(N - 1);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] rom_addr_q, rom_addr_d;
  logic [LOG2N:0]   acc_q, acc_d;
  logic [LOG2N:0]   err_sym_q, err_sym_d;
  logic [CNT_W-1:0] err_total_q, err_total_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;

  logic             accept;
  logic             mismatch;
  logic             last_bit;
  logic [CNT_W:0]   total_sum;

  // A bit is consumed only in CMP, where rom_data already holds the
  // reference bit for rom_addr (the FETCH bubble covers the ROM latency).
  assign accept    = (state_q == CMP) && bit_if.in_valid;
  assign mismatch  = bit_if.in_bit ^ rom_data;
  assign last_bit  = (rom_addr_q == LAST_ADDR);
  // One extra bit of headroom detects overflow for the saturating total.
  assign total_sum = {1'b0, err_total_q} + (CNT_W + 1)'(acc_q);

  // Next-state and datapath updates for the symbol walk; clr overrides totals last.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    acc_d       = acc_q;
    err_sym_d   = err_sym_q;
    err_total_d = err_total_q;
    sym_cnt_d   = sym_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          acc_d      = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        state_d = CMP;
      end
      CMP: begin
        if (accept) begin
          acc_d = acc_q + (LOG2N + 1)'(mismatch);
          if (last_bit) begin
            state_d = DONE;
          end else begin
            rom_addr_d = rom_addr_q + LOG2N'(1);
            state_d    = FETCH;
          end
        end
      end
      DONE: begin
        err_sym_d   = acc_q;
        err_total_d = total_sum[CNT_W] ? {CNT_W{1'b1}} : total_sum[CNT_W-1:0];
        sym_cnt_d   = sym_cnt_q + CNT_W'(1);
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Clearing the totals wins even over the DONE-cycle update.
    if (clr) begin
      err_total_d = '0;
      sym_cnt_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      acc_q       <= '0;
      err_sym_q   <= '0;
      err_total_q <= '0;
      sym_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      acc_q       <= acc_d;
      err_sym_q   <= err_sym_d;
      err_total_q <= err_total_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign bit_if.in_ready = (state_q == CMP);
  assign busy            = (state_q != IDLE);
  assign sym_done        = (state_q == DONE);
  assign rom_we          = 1'b0;
  assign rom_addr        = rom_addr_q;
  assign err_sym         = err_sym_q;
  assign err_total       = err_total_q;
  assign sym_cnt         = sym_cnt_q;

`ifdef REF_CHK_FIRST_ERR_EN
  logic             first_err_vld_q, first_err_vld_d;
  logic [LOG2N-1:0] first_err_idx_q, first_err_idx_d;

  // Latch the ROM index of the first mismatching bit; a new start clears it.
  always_comb begin
    first_err_vld_d = first_err_vld_q;
    first_err_idx_d = first_err_idx_q;
    if ((state_q == IDLE) && start) begin
      first_err_vld_d = 1'b0;
      first_err_idx_d = '0;
    end else if (accept && mismatch && !first_err_vld_q) begin
      first_err_vld_d = 1'b1;
      first_err_idx_d = rom_addr_q;
    end
  end

  // First-error capture registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      first_err_vld_q <= 1'b0;
      first_err_idx_q <= '0;
    end else begin
      first_err_vld_q <= first_err_vld_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign first_err_vld = first_err_vld_q;
  assign first_err_idx = first_err_idx_q;
`endif

endmodule

// File: tb/tb_ref_bit_checker.sv
// Directed bench for ref_bit_checker (N=48, CNT_W=8 so saturation is reachable).
// Define REF_CHK_FIRST_ERR_EN to also exercise the first-error outputs.
module tb_ref_bit_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [5:0]  rom_addr;
  logic        rom_we;
  logic        rom_data = 1'b0;
  logic        busy;
  logic        sym_done;
  logic [6:0]  err_sym;
  logic [7:0]  err_total;
  logic [7:0]  sym_cnt;
`ifdef REF_CHK_FIRST_ERR_EN
  logic        first_err_vld;
  logic [5:0]  first_err_idx;
`endif

  int errors = 0;
  int checks = 0;

  logic [47:0] ref_bits;
  logic        rom_mem [48];

  ref_bit_checker_if bit_if ();

  ref_bit_checker #(.N(48), .LOG2N(6), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .bit_if    (bit_if.slave),
    .rom_addr  (rom_addr),
    .rom_we    (rom_we),
    .rom_data  (rom_data),
    .busy      (busy),
    .sym_done  (sym_done),
    .err_sym   (err_sym),
    .err_total (err_total),
    .sym_cnt   (sym_cnt)
`ifdef REF_CHK_FIRST_ERR_EN
    ,
    .first_err_vld (first_err_vld),
    .first_err_idx (first_err_idx)
`endif
  );

  always #5 clk = ~clk;

  // Reference ROM with registered read.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Drives one symbol: pulses start, feeds bits as in_ready allows, and tracks
  // handshake rules. done_edge = edge count after the start edge at which
  // sym_done was seen high (-1 on timeout). viol counts protocol breaches.
  task automatic run_symbol(input logic [47:0] bits, input bit gaps, input int rst_at,
                            input bit clr_in_done, output int done_edge,
                            output int viol, output bit hit_rst);
    int k;
    int cyc;
    logic prev_ready;
    logic prev_acc;
    logic [5:0] prev_addr;
    logic acc;
    done_edge = -1; viol = 0; hit_rst = 1'b0;
    k = 0; cyc = 0; prev_ready = 1'b0; prev_acc = 1'b0; prev_addr = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 600) begin
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b1; bit_if.in_valid = 1'b0; hit_rst = 1'b1;
        break;
      end
      if (sym_done) begin
        done_edge = cyc;
        if (clr_in_done) clr = 1'b1;
        break;
      end
      if (prev_acc && bit_if.in_ready) viol++;
      if (prev_ready && !prev_acc && (!bit_if.in_ready || rom_addr != prev_addr)) viol++;
      if (rom_addr != 6'(k)) viol++;
      if (!busy) viol++;
      if (rom_we !== 1'b0) viol++;
      bit_if.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bit_if.in_bit   = (k < 48) ? bits[k] : 1'b0;
      acc = bit_if.in_ready && bit_if.in_valid;
      prev_ready = bit_if.in_ready; prev_acc = acc; prev_addr = rom_addr;
      if (acc) k++;
      @(negedge clk); cyc++;
    end
    bit_if.in_valid = 1'b0;
    if (!hit_rst) begin
      @(negedge clk); clr = 1'b0;
    end
    $display("symbol: accepted=%0d done_edge=%0d viol=%0d err_sym=%0d err_total=%0d sym_cnt=%0d",
             k, done_edge, viol, err_sym, err_total, sym_cnt);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    int de; int v; bit hr; int seen;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0d expected 0", busy); end
    checks++; if (bit_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0d expected 0", bit_if.in_ready); end
    checks++; if (sym_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0d expected 0", sym_done); end
    checks++; if (rom_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0d expected 0", rom_we); end
    checks++; if (rom_addr !== 6'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", rom_addr); end
    checks++; if (err_total !== 8'd0 || sym_cnt !== 8'd0 || err_sym !== 7'd0) begin
      errors++; $display("FAIL rst_counts: got %0d/%0d/%0d expected 0/0/0", err_sym, err_total, sym_cnt); end
`ifdef REF_CHK_FIRST_ERR_EN
    checks++; if (first_err_vld !== 1'b0 || first_err_idx !== 6'd0) begin
      errors++; $display("FAIL rst_first: got %0d/%0d expected 0/0", first_err_vld, first_err_idx); end
`endif
    rst_n = 1'b0;
    // A full erroneous symbol so the mid-run reset has something to clear.
    run_symbol(~ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (err_sym !== 7'd48) begin errors++; $display("FAIL pre_rst_err_sym: got %0d expected 48", err_sym); end
    run_symbol(ref_bits, 1'b0, 20, 1'b0, de, v, hr);
    checks++; if (hr !== 1'b1) begin errors++; $display("FAIL midrst_reached: got %0d expected 1", hr); end
    #1;
    checks++; if (busy !== 1'b0 || bit_if.in_ready !== 1'b0 || rom_addr !== 6'd0) begin
      errors++; $display("FAIL midrst_state: got busy=%0d ready=%0d addr=%0d expected 0/0/0", busy, bit_if.in_ready, rom_addr); end
    checks++; if (err_sym !== 7'd0 || err_total !== 8'd0 || sym_cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_counts: got %0d/%0d/%0d expected 0/0/0", err_sym, err_total, sym_cnt); end
    @(negedge clk); rst_n = 1'b0;
    bit_if.in_valid = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sym_done || busy) seen++;
    end
    bit_if.in_valid = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
    run_symbol(ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (de !== 96) begin errors++; $display("FAIL postrst_edge: got %0d expected 96", de); end
    checks++; if (err_sym !== 7'd0 || sym_cnt !== 8'd1) begin
      errors++; $display("FAIL postrst_result: got err_sym=%0d sym_cnt=%0d expected 0/1", err_sym, sym_cnt); end
  endtask

  task automatic test_match();
    int de; int v; bit hr;
    do_clr();
    run_symbol(ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (de !== 96) begin errors++; $display("FAIL match_edge: got %0d expected 96", de); end
    checks++; if (v !== 0) begin errors++; $display("FAIL match_protocol: got %0d violations expected 0", v); end
    checks++; if (err_sym !== 7'd0) begin errors++; $display("FAIL match_err_sym: got %0d expected 0", err_sym); end
    checks++; if (sym_cnt !== 8'd1 || err_total !== 8'd0) begin
      errors++; $display("FAIL match_totals: got sym_cnt=%0d err_total=%0d expected 1/0", sym_cnt, err_total); end
  endtask

  task automatic test_back_to_back();
    int de; int v; bit hr;
    do_clr();
    run_symbol(~ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (err_sym !== 7'd48 || err_total !== 8'd48) begin
      errors++; $display("FAIL b2b_first: got err_sym=%0d err_total=%0d expected 48/48", err_sym, err_total); end
    run_symbol(~ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (err_sym !== 7'd48 || err_total !== 8'd96) begin
      errors++; $display("FAIL b2b_second: got err_sym=%0d err_total=%0d expected 48/96", err_sym, err_total); end
    checks++; if (sym_cnt !== 8'd2) begin errors++; $display("FAIL b2b_sym_cnt: got %0d expected 2", sym_cnt); end
    do_clr();
    checks++; if (err_sym !== 7'd48 || err_total !== 8'd0 || sym_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_idle: got %0d/%0d/%0d expected 48/0/0", err_sym, err_total, sym_cnt); end
  endtask

  task automatic test_stall();
    int de; int v; bit hr;
    logic [47:0] bits;
    bits = ref_bits;
    bits[5] = ~bits[5]; bits[40] = ~bits[40];
    do_clr();
    run_symbol(bits, 1'b1, -1, 1'b0, de, v, hr);
    checks++; if (de < 96) begin errors++; $display("FAIL stall_edge: got %0d expected >= 96", de); end
    checks++; if (v !== 0) begin errors++; $display("FAIL stall_protocol: got %0d violations expected 0", v); end
    checks++; if (err_sym !== 7'd2 || err_total !== 8'd2) begin
      errors++; $display("FAIL stall_errs: got err_sym=%0d err_total=%0d expected 2/2", err_sym, err_total); end
`ifdef REF_CHK_FIRST_ERR_EN
    checks++; if (first_err_vld !== 1'b1 || first_err_idx !== 6'd5) begin
      errors++; $display("FAIL stall_first: got %0d/%0d expected 1/5", first_err_vld, first_err_idx); end
`endif
  endtask

  task automatic test_saturate();
    int de; int v; bit hr;
    do_clr();
    for (int s = 0; s < 5; s++) run_symbol(~ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (err_total !== 8'd240) begin errors++; $display("FAIL sat_before: got %0d expected 240", err_total); end
    run_symbol(~ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (err_total !== 8'd255) begin errors++; $display("FAIL sat_total: got %0d expected 255", err_total); end
    checks++; if (sym_cnt !== 8'd6) begin errors++; $display("FAIL sat_sym_cnt: got %0d expected 6", sym_cnt); end
    run_symbol(ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (err_total !== 8'd255 || err_sym !== 7'd0) begin
      errors++; $display("FAIL sat_hold: got err_total=%0d err_sym=%0d expected 255/0", err_total, err_sym); end
    run_symbol(~ref_bits, 1'b0, -1, 1'b1, de, v, hr);
    checks++; if (de !== 96) begin errors++; $display("FAIL clrdone_pulse: got %0d expected 96", de); end
    checks++; if (err_total !== 8'd0 || sym_cnt !== 8'd0) begin
      errors++; $display("FAIL clrdone_totals: got %0d/%0d expected 0/0", err_total, sym_cnt); end
    checks++; if (err_sym !== 7'd48) begin errors++; $display("FAIL clrdone_err_sym: got %0d expected 48", err_sym); end
  endtask

`ifdef REF_CHK_FIRST_ERR_EN
  task automatic test_first_err();
    int de; int v; bit hr;
    logic [47:0] bits;
    bits = ref_bits;
    bits[7] = ~bits[7]; bits[30] = ~bits[30];
    run_symbol(bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (first_err_vld !== 1'b1 || first_err_idx !== 6'd7) begin
      errors++; $display("FAIL first_err: got %0d/%0d expected 1/7", first_err_vld, first_err_idx); end
    checks++; if (err_sym !== 7'd2) begin errors++; $display("FAIL first_err_sym: got %0d expected 2", err_sym); end
    run_symbol(ref_bits, 1'b0, -1, 1'b0, de, v, hr);
    checks++; if (first_err_vld !== 1'b0) begin errors++; $display("FAIL first_err_clear: got %0d expected 0", first_err_vld); end
  endtask
`endif

  initial begin
    bit_if.in_valid = 1'b0;
    bit_if.in_bit   = 1'b0;
    for (int k = 0; k < 48; k++) begin
      ref_bits[k] = ((k % 4) == 0) || ((k % 4) == 3);
      rom_mem[k]  = ref_bits[k];
    end
    test_reset();
    test_match();
    test_back_to_back();
    test_stall();
    test_saturate();
`ifdef REF_CHK_FIRST_ERR_EN
    test_first_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
